// File: rtl/lock_pkg.sv
// Shared encodings for the combination-lock front end: FSM states and one-hot LED patterns.
package lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_OPEN    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  localparam logic [3:0] LED_IDLE    = 4'b0001;
  localparam logic [3:0] LED_WAIT    = 4'b0010;
  localparam logic [3:0] LED_OPEN    = 4'b0100;
  localparam logic [3:0] LED_LOCKOUT = 4'b1000;

  function automatic logic [3:0] state_led_of(input state_e s);
    case (s)
      ST_IDLE:    return LED_IDLE;
      ST_WAIT:    return LED_WAIT;
      ST_OPEN:    return LED_OPEN;
      ST_LOCKOUT: return LED_LOCKOUT;
      default:    return LED_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw button -> 2-FF synchronizer -> debounce -> single-cycle pulse on the debounced rising edge.
module btn_conditioner #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CW         = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d1_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q;

  // NOTE: non-blocking assignments so every flop samples its pre-edge input; the sync chain depends on it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      deb_q    <= 1'b0;
      deb_d1_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      deb_d1_q <= deb_q;
      pulse_q  <= deb_q & ~deb_d1_q;
      // Any sample agreeing with the accepted level restarts the stability run.
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        deb_q <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/lock_access_ctrl.sv
// Front end for the combination-lock core: forwards conditioned button strobes, tracks
// core results, counts consecutive failures and enforces a timed lockout.
module lock_access_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = 4,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 20,
  parameter int unsigned RESP_TIMEOUT   = 8,
  parameter int unsigned CW             = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_enter,
  input  logic       btn_oops,
  input  logic       lock_unlocked,
  input  logic       lock_error,
  output logic       enter_pulse,
  output logic       oops_pulse,
  output logic       locked_out,
  output logic [1:0] fail_cnt,
  output logic [3:0] state_led
);

  logic enter_raw, oops_raw;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_enter_cond (
    .clk(clk), .reset(reset), .btn_i(btn_enter), .pulse_o(enter_raw)
  );

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_oops_cond (
    .clk(clk), .reset(reset), .btn_i(btn_oops), .pulse_o(oops_raw)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [1:0]    fail_q, fail_d, fail_inc;
  logic          enter_q, enter_d;
  logic          oops_q, oops_d;
  logic          locked_q;
  logic [3:0]    led_q;

  // NOTE: every variable gets a default first so no branch leaves it unassigned (no inferred latches).
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    fail_d   = fail_q;
    enter_d  = 1'b0;
    oops_d   = 1'b0;
    fail_inc = fail_q + 2'd1;
    case (state_q)
      ST_IDLE, ST_OPEN: begin
        if (enter_raw) begin
          enter_d = 1'b1;
          if (state_q == ST_IDLE) begin
            state_d = ST_WAIT;
            timer_d = CW'(RESP_TIMEOUT);
          end
        end else if (oops_raw) begin
          oops_d = 1'b1;
        end
        if (state_q == ST_OPEN && !lock_unlocked) state_d = ST_IDLE;
      end
      ST_WAIT: begin
        timer_d = timer_q - CW'(1);
        // Error beats a simultaneous unlock; an unlock in the final cycle beats the timeout.
        if (lock_error || (!lock_unlocked && timer_q <= CW'(1))) begin
          fail_d = fail_inc;
          if (fail_inc == 2'(MAX_FAILS)) begin
            state_d = ST_LOCKOUT;
            timer_d = CW'(LOCKOUT_CYCLES);
          end else begin
            state_d = ST_IDLE;
          end
        end else if (lock_unlocked) begin
          state_d = ST_OPEN;
          fail_d  = '0;
        end
      end
      ST_LOCKOUT: begin
        timer_d = timer_q - CW'(1);
        if (timer_q <= CW'(1)) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      fail_q   <= '0;
      enter_q  <= 1'b0;
      oops_q   <= 1'b0;
      locked_q <= 1'b0;
      led_q    <= LED_IDLE;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      fail_q   <= fail_d;
      enter_q  <= enter_d;
      oops_q   <= oops_d;
      locked_q <= (state_d == ST_LOCKOUT);
      led_q    <= state_led_of(state_d);
    end
  end

  assign enter_pulse = enter_q;
  assign oops_pulse  = oops_q;
  assign locked_out  = locked_q;
  assign fail_cnt    = fail_q;
  assign state_led   = led_q;

endmodule

// File: tb/tb_lock_access_ctrl.sv
// Self-checking bench for lock_access_ctrl: vector table, directed corner sequences and
// randomized traffic compared against a behavioural model of the button and FSM rules.
module tb_lock_access_ctrl;

  localparam int DEB  = 4;
  localparam int MAXF = 3;
  localparam int LOCK = 20;
  localparam int TOUT = 8;

  logic       clk = 1'b0;
  logic       reset, btn_enter, btn_oops, lock_unlocked, lock_error;
  logic       enter_pulse, oops_pulse, locked_out;
  logic [1:0] fail_cnt;
  logic [3:0] state_led;
  logic [8:0] dut_out;

  always #5 clk = ~clk;

  lock_access_ctrl #(
    .DEB_CYCLES(DEB), .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCK), .RESP_TIMEOUT(TOUT), .CW(16)
  ) dut (
    .clk(clk), .reset(reset), .btn_enter(btn_enter), .btn_oops(btn_oops),
    .lock_unlocked(lock_unlocked), .lock_error(lock_error),
    .enter_pulse(enter_pulse), .oops_pulse(oops_pulse), .locked_out(locked_out),
    .fail_cnt(fail_cnt), .state_led(state_led)
  );

  assign dut_out = {enter_pulse, oops_pulse, locked_out, fail_cnt, state_led};

  int n_vec = 0;
  int n_bad = 0;
  int tot_ep = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: edge-numbered deadlines instead of down-counters, sample windows for debounce.
  typedef enum {M_IDLE, M_WAIT, M_OPEN, M_LOCK} mode_e;
  mode_e m_mode = M_IDLE;
  int    m_fails = 0;
  int    m_deadline = 0;
  int    m_edge = 0;
  bit    m_ep = 0, m_op = 0;
  bit    m_rawp[2];
  bit    m_deb[2];
  bit    m_smp[2][$];
  bit    m_win[2][$];
  bit    m_dh[2][$];

  function automatic bit qget(input bit q[$], input int back);
    if (q.size() >= back) return q[q.size() - back];
    return 1'b0;
  endfunction

  function automatic logic [8:0] model_out();
    logic [3:0] led;
    case (m_mode)
      M_IDLE:  led = 4'b0001;
      M_WAIT:  led = 4'b0010;
      M_OPEN:  led = 4'b0100;
      default: led = 4'b1000;
    endcase
    return {m_ep, m_op, (m_mode == M_LOCK), 2'(m_fails), led};
  endfunction

  task automatic model_step(input bit rst, input bit be, input bit bo, input bit lu, input bit le);
    bit btn[2];
    m_edge++;
    if (rst) begin
      m_mode = M_IDLE; m_fails = 0; m_ep = 0; m_op = 0;
      for (int b = 0; b < 2; b++) begin
        m_rawp[b] = 0; m_deb[b] = 0;
        m_smp[b].delete(); m_win[b].delete(); m_dh[b].delete();
      end
      return;
    end
    m_ep = 0; m_op = 0;
    case (m_mode)
      M_IDLE, M_OPEN: begin
        if (m_rawp[0]) begin
          m_ep = 1;
          if (m_mode == M_IDLE) begin m_mode = M_WAIT; m_deadline = m_edge + TOUT; end
        end else if (m_rawp[1]) m_op = 1;
        if (m_mode == M_OPEN && !lu) m_mode = M_IDLE;
      end
      M_WAIT: begin
        if (le || (!lu && m_edge == m_deadline)) begin
          m_fails++;
          if (m_fails == MAXF) begin m_mode = M_LOCK; m_deadline = m_edge + LOCK; end
          else m_mode = M_IDLE;
        end else if (lu) begin
          m_mode = M_OPEN; m_fails = 0;
        end
      end
      default: if (m_edge == m_deadline) begin m_mode = M_IDLE; m_fails = 0; end
    endcase
    btn[0] = be; btn[1] = bo;
    for (int b = 0; b < 2; b++) begin
      bit synced, nraw;
      synced = qget(m_smp[b], 2);               // level seen two edges after sampling
      m_smp[b].push_back(btn[b]);
      if (m_smp[b].size() > 3) void'(m_smp[b].pop_front());
      nraw = qget(m_dh[b], 1) && !qget(m_dh[b], 2);
      if (synced != m_deb[b]) begin
        m_win[b].push_back(synced);
        if (m_win[b].size() >= DEB) begin m_deb[b] = synced; m_win[b].delete(); end
      end else m_win[b].delete();
      m_dh[b].push_back(m_deb[b]);
      if (m_dh[b].size() > 3) void'(m_dh[b].pop_front());
      m_rawp[b] = nraw;
    end
  endtask

  bit drv_be = 0, drv_lu = 0;

  task automatic cycle(input bit rst, input bit be, input bit bo, input bit lu, input bit le);
    reset = rst; btn_enter = be; btn_oops = bo; lock_unlocked = lu; lock_error = le;
    @(posedge clk);
    model_step(rst, be, bo, lu, le);
    @(negedge clk);
    check("model", dut_out, model_out());
    tot_ep += int'(enter_pulse);
  endtask

  task automatic press();
    int k = 0;
    drv_be = 1;
    do begin
      cycle(0, 1, 0, drv_lu, 0);
      k++;
    end while (!enter_pulse && k < 20);
    check("press_pulse", enter_pulse, 1);
  endtask

  task automatic release_btn(input int n);
    drv_be = 0;
    repeat (n) cycle(0, 0, 0, drv_lu, 0);
  endtask

  typedef struct {
    bit rst, be, bo, lu, le;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[19];

  initial begin
    int e0, lo;
    bit rb, rbo, rlu;

    // Held enter from a fresh reset: pulse 8 edges after first sample, then silent core times out.
    for (int i = 0; i < 19; i++) begin
      tbl[i] = '{rst: 0, be: 1, bo: 0, lu: 0, le: 0, exp: 9'b0_0_0_00_0001};
      if (i >= 8 && i < 16) tbl[i].exp = 9'b0_0_0_00_0010;
      if (i >= 16) tbl[i].exp = 9'b0_0_0_01_0001;
    end
    tbl[0].rst = 1; tbl[0].be = 0;
    tbl[8].exp = 9'b1_0_0_00_0010;
    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].rst, tbl[i].be, tbl[i].bo, tbl[i].lu, tbl[i].le);
      check("tbl", dut_out, tbl[i].exp);
    end
    drv_be = 1;
    release_btn(8);

    // Short glitch is filtered.
    cycle(1, 0, 0, 0, 0);
    e0 = tot_ep;
    repeat (2) cycle(0, 1, 0, 0, 0);
    repeat (12) cycle(0, 0, 0, 0, 0);
    check("glitch_pulses", tot_ep - e0, 0);
    check("glitch_led", state_led, 4'b0001);

    // Three errors -> lockout of exactly LOCK cycles, held enter ignored throughout.
    for (int i = 0; i < 3; i++) begin
      press();
      cycle(0, 1, 0, 0, 1);
      check("fail_cnt", fail_cnt, i + 1);
      if (i < 2) release_btn(8);
    end
    check("lockout_entry", locked_out, 1);
    lo = int'(locked_out);
    e0 = tot_ep;
    repeat (30) begin
      cycle(0, 1, 0, 0, 0);
      lo += int'(locked_out);
    end
    check("lockout_len", lo, LOCK);
    check("lockout_no_pulse", tot_ep - e0, 0);
    check("post_lock_fc", fail_cnt, 0);
    check("post_lock_led", state_led, 4'b0001);
    release_btn(8);

    // Unlock with two failures pending clears the count; falling unlock returns to IDLE.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      press();
      cycle(0, 1, 0, 0, 1);
      release_btn(8);
    end
    check("pre_open_fc", fail_cnt, 2);
    press();
    drv_lu = 1;
    cycle(0, 1, 0, 1, 0);
    check("open_led", state_led, 4'b0100);
    check("open_fc", fail_cnt, 0);
    release_btn(8);
    check("open_hold", state_led, 4'b0100);
    drv_lu = 0;
    cycle(0, 0, 0, 0, 0);
    check("open_exit", state_led, 4'b0001);

    // Error and unlock together count as a failure; reset aborts a lockout.
    press();
    cycle(0, 1, 0, 1, 1);
    check("err_wins_fc", fail_cnt, 1);
    check("err_wins_led", state_led, 4'b0001);
    release_btn(8);
    for (int i = 0; i < 2; i++) begin
      press();
      cycle(0, 1, 0, 0, 1);
      release_btn(8);
    end
    repeat (5) cycle(0, 0, 0, 0, 0);
    check("mid_lockout", locked_out, 1);
    cycle(1, 0, 0, 0, 0);
    check("rst_in_lockout", dut_out, 9'b0_0_0_00_0001);

    // Randomized traffic against the model.
    rb = 0; rbo = 0; rlu = 0;
    repeat (3000) begin
      if ($urandom_range(5) == 0) rb = ~rb;
      if ($urandom_range(5) == 0) rbo = ~rbo;
      if ($urandom_range(9) == 0) rlu = ~rlu;
      cycle(($urandom_range(499) == 0), rb, rbo, rlu, ($urandom_range(11) == 0));
      if (enter_pulse && oops_pulse) check("pulse_exclusive", 2'b11, 2'b00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
